// File: rtl/cpu_log_pkg.sv
// Shared types and constants for the CPU trace-log arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_log_pkg;

    // Two trace sources, so one bit selects a source.
    localparam int SRC_W = 1;
    typedef logic [SRC_W-1:0] src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no line in progress
        ST_LINE  = 2'd1,   // streaming the owner's characters
        ST_ABORT = 2'd2    // one cycle that emits the abort character
    } state_e;

    // Record delimiters understood by the downstream checker.
    localparam logic [7:0] CH_CARET = 8'h5E;  // '^' start of line
    localparam logic [7:0] CH_HASH  = 8'h23;  // '#' end of line
    localparam logic [7:0] CH_BANG  = 8'h21;  // '!' aborted line

endpackage

// File: rtl/cpu_log_arbiter_if.sv
// Bundle of the two source handshakes and the checker-facing outputs.
// Latency: n/a (wires only).
// Backpressure: reqN_ready is driven by the arbiter (slave modport).
//   master: trace sources / environment side; slave: the arbiter.
interface cpu_log_arbiter_if;
    logic [7:0] req0_char;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_char;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic [1:0] grant;
    logic       line_done;
    logic       line_src;
    logic       abort;

    modport master (
        output req0_char, req0_valid, req1_char, req1_valid,
        input  req0_ready, req1_ready,
        input  out_char, out_valid, grant, line_done, line_src, abort
    );

    modport slave (
        input  req0_char, req0_valid, req1_char, req1_valid,
        output req0_ready, req1_ready,
        output out_char, out_valid, grant, line_done, line_src, abort
    );
endinterface

// File: rtl/cpu_log_stall_timer.sv
// Counts consecutive stalled cycles of the line owner; flags when TIMEOUT is reached.
// Latency: expired is combinational from the registered count (count==TIMEOUT).
// Backpressure: none; clear has priority over inc, count saturates at 255.
//   Ports: clk, reset (sync, active-high), clear, inc, expired.
module cpu_log_stall_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (clear) begin
            count_q <= 8'd0;
        end else if (inc && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = (count_q == 8'(TIMEOUT));
endmodule

// File: rtl/cpu_log_arbiter.sv
// Round-robin arbiter granting whole '^'..'#' trace lines from two sources to one checker.
// Latency: accepted beat appears on out_char/out_valid one cycle later; grant is registered.
// Backpressure: combinational readies; non-owner held at ready=0 during a line, non-'^' drained in idle.
//   Ports: clk, reset (sync, active-high), bus (cpu_log_arbiter_if.slave).
//   Optional CPU_LOG_ARB_TIMEOUT_EN: abort a line after TIMEOUT stalled cycles, emitting '!'.
module cpu_log_arbiter
    import cpu_log_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    cpu_log_arbiter_if.slave   bus
);
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("cpu_log_arbiter: TIMEOUT must be in 1..255");
    end

    state_e     state_q;
    src_t       owner_q;
    src_t       last_q;
    logic [7:0] out_char_q;
    logic       out_valid_q;
    logic [1:0] grant_q;
    logic       line_done_q;
    src_t       line_src_q;

    logic       caret0, caret1;
    logic       win0, win1;
    logic       rdy0, rdy1;
    logic       own_acc;
    logic [7:0] own_char;
    logic       stall_exp;

    assign caret0 = bus.req0_valid && (bus.req0_char == CH_CARET);
    assign caret1 = bus.req1_valid && (bus.req1_char == CH_CARET);
    // On a tie the source that did not own the previous line wins.
    assign win0 = caret0 && (!caret1 || (last_q == src_t'(1)));
    assign win1 = caret1 && (!caret0 || (last_q == src_t'(0)));

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (!reset) begin
            case (state_q)
                // Anything that is not a '^' is drained; a losing '^' is held.
                ST_IDLE: begin
                    rdy0 = !caret0 || win0;
                    rdy1 = !caret1 || win1;
                end
                // An expiring line must not accept a beat in the cycle it is aborted.
                ST_LINE: begin
                    rdy0 = (owner_q == src_t'(0)) && !stall_exp;
                    rdy1 = (owner_q == src_t'(1)) && !stall_exp;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;

    assign own_char = (owner_q == src_t'(1)) ? bus.req1_char : bus.req0_char;
    assign own_acc  = (owner_q == src_t'(1)) ? (bus.req1_valid && rdy1)
                                             : (bus.req0_valid && rdy0);

`ifdef CPU_LOG_ARB_TIMEOUT_EN
    logic own_vld;
    logic abort_q;

    assign own_vld = (owner_q == src_t'(1)) ? bus.req1_valid : bus.req0_valid;

    cpu_log_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_q != ST_LINE) || own_acc),
        .inc     ((state_q == ST_LINE) && !own_vld),
        .expired (stall_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= (state_q == ST_ABORT);
        end
    end

    assign bus.abort = abort_q;
`else
    assign stall_exp = 1'b0;
    assign bus.abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= src_t'(0);
            last_q      <= src_t'(1);
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            grant_q     <= 2'b00;
            line_done_q <= 1'b0;
            line_src_q  <= src_t'(0);
        end else begin
            out_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win0 || win1) begin
                        owner_q     <= src_t'(win1);
                        grant_q     <= win1 ? 2'b10 : 2'b01;
                        out_char_q  <= CH_CARET;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (own_acc) begin
                        out_char_q  <= own_char;
                        out_valid_q <= 1'b1;
                        if (own_char == CH_HASH) begin
                            line_done_q <= 1'b1;
                            line_src_q  <= owner_q;
                            last_q      <= owner_q;
                            grant_q     <= 2'b00;
                            state_q     <= ST_IDLE;
                        end
                    end else if (stall_exp) begin
                        state_q <= ST_ABORT;
                    end
                end
`ifdef CPU_LOG_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    out_char_q  <= CH_BANG;
                    out_valid_q <= 1'b1;
                    line_src_q  <= owner_q;
                    last_q      <= owner_q;
                    grant_q     <= 2'b00;
                    state_q     <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_char  = out_char_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant     = grant_q;
    assign bus.line_done = line_done_q;
    assign bus.line_src  = line_src_q;
endmodule
